// File: rtl/pcpu_pkg.sv
// Purpose: shared PCPU pipeline defaults and the IF/ID record type used by fetch and decode.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package pcpu_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // One IF/ID pipeline slot as seen by decode.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        err;
    } if_id_t;

endpackage

// File: rtl/if_stage_pc_reg.sv
// Purpose: program counter with +4 adder, redirect/stall select and misaligned-target flag.
// Latency: PC updates on the rising edge; pc4 is combinational from the registered PC.
// Backpressure: stall holds PC and pc_err; redirect overrides stall.
module pc_reg
    import pcpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC_VAL = RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        pc_err
);

    // Wraps modulo 2^32 naturally.
    assign pc4 = pc + 32'd4;

    // PC select: redirect (word-aligned target, remember misalignment) > stall > advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= RESET_PC_VAL;
            pc_err <= 1'b0;
        end else if (redirect) begin
            pc     <= {redirect_pc[31:2], 2'b00};
            pc_err <= |redirect_pc[1:0];
        end else if (!stall) begin
            pc     <= pc4;
            pc_err <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Purpose: instruction-fetch stage: drives the ROM address and captures the ROM word into IF/ID.
// Latency: one cycle from inst_addr to id_inst.
// Backpressure: stall freezes PC, IF/ID and fetch_count; redirect squashes IF/ID into a single bubble.
module if_stage
    import pcpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC_VAL = RESET_PC,
    parameter logic [31:0] NOP_INST_VAL = NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_mem,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic        id_err,
    output logic [31:0] fetch_count
);

    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pc_err;
    if_id_t      if_id;

    pc_reg #(
        .RESET_PC_VAL (RESET_PC_VAL)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .pc4         (pc4),
        .pc_err      (pc_err)
    );

    // The ROM address comes straight from the PC register, so it only moves on an edge or reset.
    assign inst_addr = pc;

    // IF/ID slot: squash to a bubble on redirect, hold on stall, otherwise capture the fetched word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_id <= '{inst: NOP_INST_VAL, pc: 32'd0, pc4: 32'd0, valid: 1'b0, err: 1'b0};
        end else if (redirect) begin
            if_id <= '{inst: NOP_INST_VAL, pc: 32'd0, pc4: 32'd0, valid: 1'b0, err: 1'b0};
        end else if (!stall) begin
            if_id <= '{inst: inst_mem, pc: pc, pc4: pc4, valid: 1'b1, err: pc_err};
        end
    end

    // Count instructions actually delivered to decode; bubbles and stalled cycles do not count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= 32'd0;
        end else if (!redirect && !stall) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    assign id_inst  = if_id.inst;
    assign id_pc    = if_id.pc;
    assign id_pc4   = if_id.pc4;
    assign id_valid = if_id.valid;
    assign id_err   = if_id.err;

endmodule

// File: tb/tb_if_stage.sv
// Purpose: self-checking bench for if_stage against a cycle-level reference model.
// Latency: checks every output one half-cycle after each rising edge.
// Backpressure: random stall/redirect mixes plus directed corner cases.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [31:0] inst_addr;
    logic [31:0] inst_mem;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        id_err;
    logic [31:0] fetch_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_err;
    logic [31:0] m_inst;
    logic [31:0] m_idpc;
    logic [31:0] m_idpc4;
    logic        m_valid;
    logic        m_ierr;
    logic [31:0] m_count;

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .inst_addr   (inst_addr),
        .inst_mem    (inst_mem),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4),
        .id_valid    (id_valid),
        .id_err      (id_err),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction ROM contents as a pure function of the byte address.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign inst_mem = rom(inst_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0000_0000;
        m_err   = 1'b0;
        m_inst  = 32'h0000_0000;
        m_idpc  = 32'd0;
        m_idpc4 = 32'd0;
        m_valid = 1'b0;
        m_ierr  = 1'b0;
        m_count = 32'd0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".inst_addr"},   inst_addr,   m_pc);
        check({tag, ".id_inst"},     id_inst,     m_inst);
        check({tag, ".id_pc"},       id_pc,       m_idpc);
        check({tag, ".id_pc4"},      id_pc4,      m_idpc4);
        check({tag, ".id_valid"},    id_valid,    m_valid);
        check({tag, ".id_err"},      id_err,      m_ierr);
        check({tag, ".fetch_count"}, fetch_count, m_count);
    endtask

    // Called at a falling edge: apply inputs, take one rising edge, check at the next falling edge.
    task automatic step(input logic s, input logic r, input logic [31:0] rpc, input string tag);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        @(posedge clk);
        if (r) begin
            m_inst  = 32'h0000_0000;
            m_idpc  = 32'd0;
            m_idpc4 = 32'd0;
            m_valid = 1'b0;
            m_ierr  = 1'b0;
            m_pc    = rpc & 32'hFFFF_FFFC;
            m_err   = (rpc % 4) != 0;
        end else if (!s) begin
            m_inst  = rom(m_pc);
            m_idpc  = m_pc;
            m_idpc4 = m_pc + 32'd4;
            m_valid = 1'b1;
            m_ierr  = m_err;
            m_err   = 1'b0;
            m_pc    = m_pc + 32'd4;
            m_count = m_count + 32'd1;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between edges; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        model_reset();
        @(negedge clk);
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Straight-line fetch from RESET_PC
        step(0, 0, 0, "run0");
        check("run0.first_valid", id_valid, 1);
        step(0, 0, 0, "run1");
        check("run1.id_pc", id_pc, 32'h4);

        // Stall two cycles while id_pc=4
        step(1, 0, 0, "stall0");
        step(1, 0, 0, "stall1");
        check("stall.inst_addr", inst_addr, 32'h8);
        check("stall.id_inst", id_inst, rom(32'h4));
        step(0, 0, 0, "resume");
        check("resume.id_pc", id_pc, 32'h8);
        check("resume.count", fetch_count, 32'd3);
        step(0, 0, 0, "run3");

        // Redirect to 0x40: one bubble, then target
        step(0, 1, 32'h40, "redir40");
        check("redir40.inst_addr", inst_addr, 32'h40);
        check("redir40.bubble", id_valid, 0);
        step(0, 0, 0, "tgt40");
        check("tgt40.id_pc", id_pc, 32'h40);

        // Redirect and stall together: redirect wins
        step(1, 1, 32'h20, "redir_stall");
        check("redir_stall.inst_addr", inst_addr, 32'h20);
        step(0, 0, 0, "tgt20");

        // Misaligned redirect target
        step(0, 1, 32'h42, "redir42");
        check("redir42.inst_addr", inst_addr, 32'h40);
        step(0, 0, 0, "err0");
        check("err0.id_err", id_err, 1);
        step(0, 0, 0, "err1");
        check("err1.id_err", id_err, 0);

        // Run up to id_pc=0x10, then async reset mid-cycle
        step(0, 1, 32'h0, "redir0");
        for (int i = 0; i < 5; i++) step(0, 0, 0, "to10");
        check("pre_rst.id_pc", id_pc, 32'h10);
        async_reset("midrst");
        step(0, 0, 0, "after_rst");
        check("after_rst.id_pc", id_pc, 32'h0);

        // Address wrap at the top of memory
        step(0, 1, 32'hFFFF_FFFC, "redir_top");
        step(0, 0, 0, "wrap");
        check("wrap.id_pc4", id_pc4, 32'h0);
        check("wrap.inst_addr", inst_addr, 32'h0);

        // Randomized stall/redirect traffic
        for (int i = 0; i < 400; i++) begin
            logic s;
            logic r;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 7) == 0);
            t = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            step(s, r, t, "rand");
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rand_rst");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the PCPU pipeline.
- Owns the program counter and drives `inst_addr` to the instruction ROM.
- Captures the combinational ROM word `inst_mem` into the IF/ID pipeline register.
- Honours stall requests from the hazard unit and redirect requests from branch/jump resolution.
- Sits directly upstream of the decode stage; its outputs are decode's only instruction source.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INST`, 32'h0000_0000: instruction word injected into IF/ID on reset or squash.
- `clk`  in  1: pipeline clock; all state updates on rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `inst_addr`  out  32: current fetch PC, equal to the internal PC register (byte address, word-aligned).
- `inst_mem`  in  32: instruction word at `inst_addr`, valid combinationally in the same cycle.
- `stall`  in  1: hold PC and IF/ID contents.
- `redirect`  in  1: squash the instruction in IF/ID and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32: redirect target byte address.
- `id_inst`  out  32: registered instruction for decode.
- `id_pc`  out  32: registered PC of `id_inst`.
- `id_pc4`  out  32: registered `id_pc + 4`.
- `id_valid`  out  1: `id_inst` is a real fetched instruction, not a bubble.
- `id_err`  out  1: registered misaligned-target flag for the instruction in IF/ID.
- `fetch_count`  out  32: number of instructions delivered to ID since reset.

## Operation
- Reset values (asserted asynchronously while `rst`=0):
  - PC = `RESET_PC`; `id_inst` = `NOP_INST`; `id_pc` = 0; `id_pc4` = 0.
  - `id_valid` = 0; `id_err` = 0; `fetch_count` = 0.
- Priority per edge: reset > redirect > stall > normal.
- Normal (`redirect`=0, `stall`=0):
  - IF/ID <= {`inst_mem`, PC, PC+4, valid=1, err=pc_err}.
  - PC <= PC+4.
  - `fetch_count` += 1.
- Stall (`stall`=1, `redirect`=0): PC, IF/ID and `fetch_count` hold.
- Redirect (`redirect`=1, any `stall`):
  - IF/ID <= {`NOP_INST`, 0, 0, valid=0, err=0}.
  - PC <= {`redirect_pc[31:2]`, 2'b00}.
  - pc_err <= (`redirect_pc[1:0]` != 0).
  - `fetch_count` holds.
- pc_err is an internal 1-bit register:
  - Set by a misaligned redirect.
  - Travels into `id_err` with the first instruction fetched from the aligned target.
  - Cleared on the next normal advance.
- Arithmetic is modulo 2^32:
  - PC 32'hFFFF_FFFC + 4 wraps to 0.
  - `id_pc4` wraps identically.
  - `fetch_count` wraps to 0.

## Timing
- Fetch latency is one cycle: the word addressed in cycle N appears on `id_inst` after edge N.
- First rising edge after `rst` deasserts loads the word at `RESET_PC` into ID with `id_valid`=1.
- Redirect costs exactly one bubble: `id_valid`=0 for one cycle, and the target instruction is in ID one edge later unless stalled.
- `inst_addr` changes only on a rising edge or on reset assertion; no combinational path from `stall` or `redirect` to `inst_addr`.
- `rst` asserted mid-operation forces all outputs to reset values immediately; no partial update completes.

## Structure
- Shared package `pcpu_pkg` holds `RESET_PC` and `NOP_INST` defaults, plus the IF/ID record type {inst, pc, pc4, valid, err}. The decode stage uses the same type.
- One sub-module is natural: `pc_reg`, containing PC, pc_err, the +4 adder and redirect/stall select.
- The IF/ID register and the counter live in `if_stage` itself.

## Test plan
- Reset then run with ROM[0..3]=A,B,C,D, no stall:
  - `inst_addr` steps 0,4,8,C.
  - `id_inst` A,B,C one cycle later with `id_pc` 0,4,8.
  - `fetch_count` reaches 3.
- `stall`=1 for 2 cycles while `id_pc`=4:
  - `inst_addr` holds 8; `id_inst` holds B.
  - Fetch resumes with C at `id_pc`=8.
- `redirect`=1, `redirect_pc`=0x40:
  - Next cycle `id_valid`=0, `id_inst`=`NOP_INST`, `inst_addr`=0x40.
  - Following cycle `id_pc`=0x40, `id_valid`=1.
- `redirect`=1 and `stall`=1 together with `redirect_pc`=0x20: redirect wins, `inst_addr`=0x20, bubble in ID.
- `redirect_pc`=0x42:
  - `inst_addr`=0x40.
  - The instruction from 0x40 reaches ID with `id_err`=1.
  - The next instruction has `id_err`=0.
- `rst` pulsed low asynchronously mid-cycle while `id_pc`=0x10: outputs return to reset values before the next edge, and fetch restarts at `RESET_PC`.
